// File: rtl/pe_mac_row.sv
// pe_mac_row: one row of a spiking-input multiply-accumulate processing element.
// Packets load a weight filter and a 1-bit spike window. Once both are valid,
// a window update runs TAPS accumulate cycles. Results from ROWS windows are
// summed into one saturating partial sum, which is held until it is consumed.
module pe_mac_row #(
    parameter int TAPS   = 3,
    parameter int WT_W   = 8,
    parameter int PSUM_W = 12,
    parameter int ROWS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_type,
    input  logic [TAPS*WT_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PSUM_W-1:0]      out_psum,
    output logic                   out_sat,
    output logic                   busy
);

    localparam int TC_W  = $clog2(TAPS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SC_W  = $clog2(TAPS + 1);
    // One extra bit so that an add past full scale is visible before clipping.
    localparam int SUM_W = ((PSUM_W > WT_W) ? PSUM_W : WT_W) + 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    typedef enum logic [1:0] {
        PKT_CLEAR  = 2'b00,
        PKT_FILTER = 2'b01,
        PKT_WLOAD  = 2'b10,
        PKT_WSHIFT = 2'b11
    } pkt_t;

    state_t              state_q, state_d;
    logic [TAPS*WT_W-1:0] filt_q;
    logic [TAPS-1:0]     window_q;
    logic [PSUM_W-1:0]   acc_q;
    logic [ROW_W-1:0]    row_q;
    logic [TC_W-1:0]     tap_q;
    logic [SC_W-1:0]     shift_q;
    logic                sat_q;
    logic                filter_ok_q;
    logic                win_ok_q;

    pkt_t                pkt;
    logic                accept;
    logic                do_clear;
    logic [SC_W-1:0]     shift_inc;
    logic                win_ok_after;
    logic                start;
    logic [WT_W-1:0]     cur_wt;
    logic                cur_bit;
    logic [SUM_W-1:0]    sum;
    logic                clip;
    logic                last_tap;
    logic                last_row;

    // Decode the incoming packet and decide whether it starts a computation.
    // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        pkt          = pkt_t'(in_type);
        accept       = in_valid && (state_q == IDLE);
        do_clear     = rst || (accept && (pkt == PKT_CLEAR));
        shift_inc    = (shift_q == SC_W'(TAPS)) ? shift_q : shift_q + 1'b1;
        win_ok_after = win_ok_q;
        case (pkt)
            PKT_WLOAD:  win_ok_after = 1'b1;
            PKT_WSHIFT: if (shift_inc == SC_W'(TAPS)) win_ok_after = 1'b1;
            default:    ;
        endcase
        start = accept && ((pkt == PKT_WLOAD) || (pkt == PKT_WSHIFT))
                && filter_ok_q && win_ok_after;
    end

    // Select the current tap's weight and spike, and form the saturating sum.
    always_comb begin
        cur_wt  = '0;
        cur_bit = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            if (tap_q == TC_W'(k)) begin
                cur_wt  = filt_q[k*WT_W +: WT_W];
                cur_bit = window_q[k];
            end
        end
        sum      = SUM_W'(acc_q) + SUM_W'(cur_wt);
        clip     = cur_bit && (sum > SUM_W'({PSUM_W{1'b1}}));
        last_tap = (tap_q == TC_W'(TAPS - 1));
        last_row = (row_q == ROW_W'(ROWS - 1));
    end

    // Next-state logic and handshake/result outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_psum  = '0;
        out_sat   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (start) state_d = MAC;
            end
            MAC: begin
                if (last_tap) state_d = last_row ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                out_psum  = acc_q;
                out_sat   = sat_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any computation in flight.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Filter, window, accumulator and counters.
    // NOTE: the filter storage is a plain register bank and is cleared here, since a clear packet must zero it.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            filt_q      <= '0;
            window_q    <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            tap_q       <= '0;
            shift_q     <= '0;
            sat_q       <= 1'b0;
            filter_ok_q <= 1'b0;
            win_ok_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (pkt)
                            PKT_FILTER: begin
                                filt_q      <= in_data;
                                filter_ok_q <= 1'b1;
                            end
                            PKT_WLOAD: begin
                                window_q <= in_data[TAPS-1:0];
                                win_ok_q <= 1'b1;
                            end
                            PKT_WSHIFT: begin
                                window_q <= {window_q[TAPS-2:0], in_data[0]};
                                shift_q  <= shift_inc;
                                win_ok_q <= win_ok_after;
                            end
                            default: ;
                        endcase
                    end
                end
                MAC: begin
                    if (cur_bit) begin
                        if (clip) begin
                            acc_q <= {PSUM_W{1'b1}};
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= sum[PSUM_W-1:0];
                        end
                    end
                    if (last_tap) begin
                        tap_q <= '0;
                        if (!last_row) row_q <= row_q + 1'b1;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q <= '0;
                        row_q <= '0;
                        sat_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_row.sv
// tb_pe_mac_row: directed and randomized checks of pe_mac_row against a
// packet-level reference model (weights, spike window, saturating sum).
module tb_pe_mac_row;

    localparam int TAPS   = 3;
    localparam int WT_W   = 8;
    localparam int PSUM_W = 12;
    localparam int MAXV   = (1 << PSUM_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    // Instance with ROWS=1
    logic                  in_valid, in_ready, out_valid, out_ready, out_sat, busy;
    logic [1:0]            in_type;
    logic [TAPS*WT_W-1:0]  in_data;
    logic [PSUM_W-1:0]     out_psum;
    // Instance with ROWS=8
    logic                  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_busy;
    logic [1:0]            b_in_type;
    logic [TAPS*WT_W-1:0]  b_in_data;
    logic [PSUM_W-1:0]     b_out_psum;

    pe_mac_row #(.TAPS(TAPS), .WT_W(WT_W), .PSUM_W(PSUM_W), .ROWS(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_sat(out_sat),
        .busy(busy)
    );

    pe_mac_row #(.TAPS(TAPS), .WT_W(WT_W), .PSUM_W(PSUM_W), .ROWS(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_type(b_in_type), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_psum(b_out_psum), .out_sat(b_out_sat),
        .busy(b_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the packet stream means, not how the RTL does it.
    int       m_w [TAPS];
    bit [TAPS-1:0] m_win;
    bit       m_fok, m_wok;
    int       m_shifts;

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) m_w[k] = 0;
        m_win = '0; m_fok = 0; m_wok = 0; m_shifts = 0;
    endfunction

    // Apply an accepted packet; returns 1 if it launches a computation.
    function automatic bit model_pkt(input logic [1:0] t, input logic [TAPS*WT_W-1:0] dat);
        bit st = 0;
        case (t)
            2'b00: model_clear();
            2'b01: begin
                for (int k = 0; k < TAPS; k++) m_w[k] = int'(dat[k*WT_W +: WT_W]);
                m_fok = 1;
            end
            2'b10: begin
                m_win = dat[TAPS-1:0];
                m_wok = 1;
                st = m_fok;
            end
            default: begin
                m_win = {m_win[TAPS-2:0], dat[0]};
                m_shifts++;
                if (m_shifts >= TAPS) m_wok = 1;
                st = m_fok && m_wok;
            end
        endcase
        return st;
    endfunction

    function automatic int model_total();
        int s = 0;
        for (int k = 0; k < TAPS; k++) if (m_win[k]) s += m_w[k];
        return s;
    endfunction

    // Send one packet to the ROWS=1 instance and follow it to completion.
    // hold: cycles to keep out_ready low in OUT while hammering in_valid.
    task automatic run_pkt(input logic [1:0] t, input logic [TAPS*WT_W-1:0] dat,
                           input int hold, output logic [31:0] got);
        bit exp_start;
        int total, exp_psum, waited;
        bit exp_sat;
        got = '0;
        waited = 0;
        while (!in_ready && waited < 20) begin @(negedge clk); waited++; end
        check("a_ready_timeout", 32'(waited < 20), 1);
        in_valid = 1'b1; in_type = t; in_data = dat;
        @(posedge clk);
        exp_start = model_pkt(t, dat);
        total    = model_total();
        exp_psum = (total > MAXV) ? MAXV : total;
        exp_sat  = (total > MAXV);
        @(negedge clk);
        in_valid = 1'b0;
        check("a_busy_after_accept", busy, exp_start);
        if (!exp_start) begin
            check("a_ready_stays", in_ready, 1);
        end else begin
            for (int i = 1; i < TAPS; i++) begin
                if (hold > 0) begin in_valid = 1'b1; in_type = 2'b00; end
                @(negedge clk);
                check("a_no_early_valid", out_valid, 0);
                check("a_psum_zero_in_mac", out_psum, 0);
            end
            @(negedge clk);
            check("a_out_valid", out_valid, 1);
            check("a_out_psum", out_psum, exp_psum);
            check("a_out_sat", out_sat, exp_sat);
            got = 32'(out_psum);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; in_type = 2'b00;
                @(negedge clk);
                check("a_hold_valid", out_valid, 1);
                check("a_hold_psum", out_psum, exp_psum);
                check("a_hold_ready", in_ready, 0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("a_idle_after_collect", busy, 0);
            check("a_valid_after_collect", out_valid, 0);
            check("a_psum_after_collect", out_psum, 0);
            check("a_ready_after_collect", in_ready, 1);
        end
    endtask

    // Directed and random sequence for both instances.
    initial begin
        logic [31:0] got;
        int waited, b_total, r_sel, hold;
        logic [1:0] t;

        rst = 1'b1; in_valid = 1'b0; in_type = '0; in_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_type = '0; b_in_data = '0; b_out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_psum", out_psum, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        model_clear();

        // Basic filter/window computation, then a shift.
        run_pkt(2'b01, 24'h030201, 0, got);
        run_pkt(2'b10, 24'h000005, 0, got);
        check("basic_psum", got, 4);
        run_pkt(2'b11, 24'h000001, 0, got);
        check("shift_psum", got, 3);

        // After clear, shifts without a filter never compute.
        run_pkt(2'b00, 24'h0, 0, got);
        run_pkt(2'b11, 24'h000001, 0, got);
        check("no_filter_busy", busy, 0);
        run_pkt(2'b11, 24'h000000, 0, got);
        run_pkt(2'b11, 24'h000001, 0, got);
        run_pkt(2'b01, 24'h102030, 0, got);
        check("filter_no_start", busy, 0);
        run_pkt(2'b11, 24'h000001, 0, got);
        check("shift_fill_psum", got, 80);

        // Back-pressure: result held for 5 cycles, in_valid ignored throughout.
        run_pkt(2'b10, 24'h000006, 5, got);
        check("hold_psum", got, 48);
        run_pkt(2'b10, 24'h000004, 0, got);
        check("retained_after_hold", got, 16);

        // Reset on the second MAC cycle abandons the result.
        in_valid = 1'b1; in_type = 2'b10; in_data = 24'h000007;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
        end
        run_pkt(2'b01, 24'h0A0B0C, 0, got);
        run_pkt(2'b10, 24'h000007, 0, got);
        check("fresh_psum", got, 33);

        // Random packet stream against the model.
        for (int n = 0; n < 40; n++) begin
            r_sel = $urandom_range(0, 9);
            t = (r_sel == 0) ? 2'b00 : (r_sel < 3) ? 2'b01 : (r_sel < 6) ? 2'b10 : 2'b11;
            hold = $urandom_range(0, 2);
            run_pkt(t, 24'($urandom()), hold, got);
        end

        // ROWS=8 instance: eight full windows of max weights saturate.
        b_in_valid = 1'b1; b_in_type = 2'b01; b_in_data = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_total = 0;
        for (int r = 0; r < 8; r++) begin
            waited = 0;
            while (!b_in_ready && waited < 20) begin @(negedge clk); waited++; end
            check("b_ready_timeout", 32'(waited < 20), 1);
            b_in_valid = 1'b1; b_in_type = 2'b10; b_in_data = 24'h000007;
            @(posedge clk);
            @(negedge clk);
            b_in_valid = 1'b0;
            for (int k = 0; k < TAPS; k++) b_total += 255;
            waited = 0;
            while (b_busy && !b_out_valid && waited < 20) begin @(negedge clk); waited++; end
            check("b_row_timeout", 32'(waited < 20), 1);
            if (r < 7) begin
                check("b_row_no_valid", b_out_valid, 0);
                check("b_row_psum_zero", b_out_psum, 0);
            end else begin
                check("b_out_valid", b_out_valid, 1);
                check("b_out_psum", b_out_psum, (b_total > MAXV) ? MAXV : b_total);
                check("b_out_sat", b_out_sat, 32'(b_total > MAXV));
            end
        end
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_valid_after_collect", b_out_valid, 0);
        check("b_sat_after_collect", b_out_sat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_mac_row.md
PE_MAC_ROW -- requirements
Module: pe_mac_row

Interface
REQ-001 SHALL have parameter TAPS, default 3, filter taps per row (>=2).
REQ-002 SHALL have parameter WT_W, default 8, weight width in bits.
REQ-003 SHALL have parameter PSUM_W, default 12, partial-sum width in bits.
REQ-004 SHALL have parameter ROWS, default 1, number of window results summed per emitted psum.
REQ-005 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port in_valid  in  1  input packet present.
REQ-008 SHALL have port in_ready  out  1  block can accept a packet.
REQ-009 SHALL have port in_type  in  2  00 clear, 01 filter load, 10 window load, 11 window shift.
REQ-010 SHALL have port in_data  in  TAPS*WT_W  payload; weight k = in_data[k*WT_W +: WT_W]; window bits = in_data[TAPS-1:0].
REQ-011 SHALL have port out_valid  out  1  psum result present.
REQ-012 SHALL have port out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port out_psum  out  PSUM_W  result value.
REQ-014 SHALL have port out_sat  out  1  result saturated.
REQ-015 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-016 SHALL accept a packet only on a clk edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL implement states IDLE, MAC, OUT; no other states.
REQ-018 Clear (00): filter, window, accumulator, row counter, tap counter, sat flag, filter_ok, win_ok all zeroed; stays IDLE.
REQ-019 Filter load (01): store in_data as weights, set filter_ok; never starts a computation.
REQ-020 Window load (10): window <= in_data[TAPS-1:0], set win_ok.
REQ-021 Window shift (11): window <= {window[TAPS-2:0], in_data[0]}; shift count increments, win_ok set once TAPS shifts occur since clear/reset.
REQ-022 A window load or shift accepted with filter_ok=1 and win_ok (after the update)=1 SHALL move IDLE->MAC; otherwise remain IDLE.
REQ-023 MAC SHALL last exactly TAPS cycles, tap k=0..TAPS-1 in order, adding weight k to accumulator iff window bit k=1 (ifmap bits are 1-bit spikes).
REQ-024 Weights SHALL be unsigned; accumulator PSUM_W bits, saturating at 2^PSUM_W-1; any clipped add sets sat flag for the current result.
REQ-025 After the last MAC cycle: if row counter = ROWS-1 go to OUT, else increment row counter and return to IDLE keeping accumulator.
REQ-026 In OUT: out_valid=1, out_psum=accumulator, out_sat=sat flag, all stable until out_ready=1.
REQ-027 On OUT with out_ready=1: go IDLE, clear accumulator, row counter, sat flag; filter, window, filter_ok, win_ok retained.
REQ-028 Latency: packet accepted at edge N with ROWS=1 -> out_valid high from cycle after edge N+TAPS.
REQ-029 out_psum and out_sat SHALL be 0 whenever out_valid=0.
REQ-030 in_valid asserted outside IDLE SHALL be ignored (held off by in_ready=0), no state change.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear all state as a clear packet, overriding any simultaneous handshake.
REQ-032 During/after reset: in_ready=1 (once rst=0), out_valid=0, out_psum=0, out_sat=0, busy=0.
REQ-033 rst asserted mid-MAC or in OUT SHALL abandon the result; no out_valid follows.

Verification
REQ-034 Defaults; filter 0x030201, window load 3'b101 -> after 3 MAC cycles out_psum=4, out_sat=0.
REQ-035 Continue: shift in 1 -> window 3'b011, out_psum=3; shift before filter load after clear -> no computation, busy=0.
REQ-036 ROWS=8, filter 0xFFFFFF, 8 window loads 3'b111 -> single out_psum=4095, out_sat=1.
REQ-037 Hold out_ready=0 for 5 cycles in OUT -> out_psum stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-038 rst on 2nd MAC cycle -> next cycle busy=0, out_valid=0; new filter+window yields correct fresh result.
